fib_sequencer: RTL and testbench
================================

Name: fib_sequencer

Overview:
- Control FSM for the Fibonacci display datapath.
- Accepts a debounced start pulse and a 2-digit BCD iteration count.
- Sequences three external units over start/done handshakes: BCD-to-binary converter, Fibonacci engine, binary-to-BCD converter.
- Validates inputs, detects overflow, holds the 4-digit BCD result for the seven-segment driver, and reports errors.

Parameters:
- N_W, 7, width of the binary iteration count (covers 0..99).
- RESULT_W, 14, width of the binary Fibonacci result.
- MAX_N, 20, largest n whose result fits 4 BCD digits (fib(20)=6765).
- TIMEOUT_CYCLES, 1000000, per-stage watchdog limit (used only with FIB_WATCHDOG_EN).

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous active-high reset
- start_i  in  1  debounced one-cycle start request
- iterations_bcd_i  in  8  two BCD digits of n
- b2b_start_o  out  1  BCD-to-binary start pulse
- b2b_bcd_o  out  8  latched BCD operand
- b2b_done_i  in  1  BCD-to-binary done pulse
- b2b_bin_i  in  N_W  converted n
- fib_start_o  out  1  Fibonacci engine start pulse
- fib_n_o  out  N_W  latched n
- fib_done_i  in  1  Fibonacci done pulse
- fib_result_i  in  RESULT_W  fib(n)
- bin2bcd_start_o  out  1  binary-to-BCD start pulse
- bin2bcd_bin_o  out  RESULT_W  latched fib(n)
- bin2bcd_done_i  in  1  binary-to-BCD done pulse
- bin2bcd_bcd_i  in  16  4 BCD digits
- result_bcd_o  out  16  held display value
- busy_o  out  1  sequence in progress
- done_tick_o  out  1  one-cycle completion pulse
- error_o  out  1  sticky error flag, valid until next start
- err_code_o  out  2  error code: 0 none, 1 bad BCD, 2 overflow, 3 timeout

Behaviour:
- Clock, reset: one clock, clk_i. reset_i is synchronous, active-high, and sampled on the clk_i edge.
- Reset values: all outputs 0; state IDLE.
- States: IDLE, CHECK, B2B, FIB, B2BCD, DONE, ERROR. All outputs are registered.
- IDLE/DONE/ERROR + start_i:
  - latch iterations_bcd_i into b2b_bcd_o;
  - clear error_o/err_code_o;
  - go to CHECK.
- start_i in any other state is ignored; no queueing.
- CHECK (1 cycle):
  - either nibble >9 -> ERROR, code 1;
  - else -> B2B with b2b_start_o high for exactly the first cycle of B2B.
- Start pulses: each *_start_o is a one-cycle pulse in the first cycle of its state. The matching done_i is accepted only from the following cycle onward; done_i in the pulse cycle or in any other state is ignored.
- B2B + b2b_done_i: capture b2b_bin_i into fib_n_o.
  - value > MAX_N -> ERROR, code 2;
  - else -> FIB with fib_start_o pulse.
- FIB + fib_done_i: capture fib_result_i into bin2bcd_bin_o; -> B2BCD with pulse.
- B2BCD + bin2bcd_done_i: capture bin2bcd_bcd_i into result_bcd_o; -> DONE.
  - done_tick_o is high in the first DONE cycle only.
- busy_o: high in CHECK, B2B, FIB, B2BCD.
- result_bcd_o: updated only on a successful completion; holds its value through ERROR and new runs until overwritten.
- Reset mid-sequence: return to IDLE next edge; no start pulses issued; sub-units share reset_i, so no abort handshake.
- Boundaries:
  - n=0 and n=1 are legal and are passed to the engine unchanged.
  - n=MAX_N is legal; n=MAX_N+1 overflows.
- Simultaneous start_i and reset_i: reset wins.

Optional Feature:
- Macro FIB_WATCHDOG_EN.
- Defined:
  - a counter clears on entry to B2B/FIB/B2BCD and increments each cycle in those states;
  - reaching TIMEOUT_CYCLES-1 without done -> ERROR, code 3, no further start pulses.
- Undefined: no counter; the FSM waits indefinitely; code 3 never produced.

Decomposition:
- Package fib_pkg:
  - state enum;
  - err_code enum (ERR_NONE, ERR_BCD, ERR_OVF, ERR_TIMEOUT);
  - MAX_N default;
  - BCD digit max constant (9).
- Sub-module stage_watchdog (counter + timeout flag, clear/enable inputs), instantiated only under FIB_WATCHDOG_EN.

Test Plan:
- Nominal run: iterations 8'h15, b2b returns 15, fib returns 610, bin2bcd returns 16'h0610.
  - Required: one pulse on each start output, in order.
  - fib_n_o=15, bin2bcd_bin_o=610, result_bcd_o=16'h0610.
  - done_tick_o one cycle; busy_o low after.
- Bad BCD: 8'h1A.
  - Required: error_o=1, err_code_o=1 two cycles after start.
  - No *_start_o pulses; result_bcd_o unchanged.
- Overflow: 8'h21, b2b returns 21.
  - Required: ERROR with code 2; fib_start_o never pulses.
  - Boundary companion: 8'h20 completes with 16'h6765.
- Busy and early done:
  - start_i repeated during FIB is ignored;
  - fib_done_i asserted in the fib_start_o cycle is ignored;
  - fib_done_i one cycle later advances the FSM.
- Reset mid-FIB: reset_i one cycle.
  - Required: next cycle IDLE, all outputs 0.
  - A new start with 8'h01 completes with 16'h0001.
- Watchdog (FIB_WATCHDOG_EN, TIMEOUT_CYCLES=16): fib_done_i held low.
  - Required: ERROR with code 3 at cycle 16 of FIB.
  - Without the macro: still in FIB after 100 cycles.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and constants for the Fibonacci display sequencer.
// The optional per-stage watchdog is enabled with the FIB_WATCHDOG_EN macro.
package fib_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_B2B,
        ST_FIB,
        ST_B2BCD,
        ST_DONE,
        ST_ERROR
    } state_e;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_BCD     = 2'd1,
        ERR_OVF     = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    // fib(20) = 6765 is the largest value that fits four BCD digits.
    localparam int         MAX_N_DEFAULT = 20;
    localparam logic [3:0] BCD_DIGIT_MAX = 4'd9;

    function automatic logic bcd_pair_valid(input logic [7:0] bcd);
        return (bcd[7:4] <= BCD_DIGIT_MAX) && (bcd[3:0] <= BCD_DIGIT_MAX);
    endfunction

endpackage

// File: rtl/fib_sequencer_if.sv
// Handshake bundle between the sequencer (master) and its start input,
// the three conversion/compute units and the display side (slave).
interface fib_sequencer_if #(
    parameter int N_W      = 7,
    parameter int RESULT_W = 14
);
    logic                start_i;
    logic [7:0]          iterations_bcd_i;

    logic                b2b_start_o;
    logic [7:0]          b2b_bcd_o;
    logic                b2b_done_i;
    logic [N_W-1:0]      b2b_bin_i;

    logic                fib_start_o;
    logic [N_W-1:0]      fib_n_o;
    logic                fib_done_i;
    logic [RESULT_W-1:0] fib_result_i;

    logic                bin2bcd_start_o;
    logic [RESULT_W-1:0] bin2bcd_bin_o;
    logic                bin2bcd_done_i;
    logic [15:0]         bin2bcd_bcd_i;

    logic [15:0]         result_bcd_o;
    logic                busy_o;
    logic                done_tick_o;
    logic                error_o;
    logic [1:0]          err_code_o;

    modport master (
        input  start_i, iterations_bcd_i,
        input  b2b_done_i, b2b_bin_i,
        input  fib_done_i, fib_result_i,
        input  bin2bcd_done_i, bin2bcd_bcd_i,
        output b2b_start_o, b2b_bcd_o,
        output fib_start_o, fib_n_o,
        output bin2bcd_start_o, bin2bcd_bin_o,
        output result_bcd_o, busy_o, done_tick_o, error_o, err_code_o
    );

    modport slave (
        output start_i, iterations_bcd_i,
        output b2b_done_i, b2b_bin_i,
        output fib_done_i, fib_result_i,
        output bin2bcd_done_i, bin2bcd_bcd_i,
        input  b2b_start_o, b2b_bcd_o,
        input  fib_start_o, fib_n_o,
        input  bin2bcd_start_o, bin2bcd_bin_o,
        input  result_bcd_o, busy_o, done_tick_o, error_o, err_code_o
    );

endinterface

// File: rtl/stage_watchdog.sv
// Per-stage cycle counter for the sequencer; raises timeout in the
// TIMEOUT_CYCLES-th cycle of a stage. Only built with FIB_WATCHDOG_EN.
module stage_watchdog #(
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] count;

    // clear marks the first stage cycle, so count equals cycles already spent.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count <= '0;
        end else if (clear) begin
            count <= CNT_W'(1);
        end else if (enable && !timeout) begin
            count <= count + CNT_W'(1);
        end
    end

    assign timeout = enable && !clear && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/fib_sequencer.sv
// Control FSM sequencing BCD->binary, Fibonacci engine and binary->BCD units.
// Define FIB_WATCHDOG_EN to add a per-stage timeout (error code 3).
module fib_sequencer
    import fib_pkg::*;
#(
    parameter int N_W   = 7,
    parameter int MAX_N = MAX_N_DEFAULT
`ifdef FIB_WATCHDOG_EN
    ,
    parameter int TIMEOUT_CYCLES = 1000000
`endif
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    fib_sequencer_if.master       bus
);

    state_e state;
    logic   stage_timeout;

`ifdef FIB_WATCHDOG_EN
    logic stage_active;
    logic stage_entry;

    assign stage_active = (state == ST_B2B) || (state == ST_FIB) || (state == ST_B2BCD);
    assign stage_entry  = bus.b2b_start_o | bus.fib_start_o | bus.bin2bcd_start_o;

    stage_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear   (stage_entry),
        .enable  (stage_active),
        .timeout (stage_timeout)
    );
`else
    assign stage_timeout = 1'b0;
`endif

    // The registered start pulse doubles as the "first cycle of this stage"
    // marker, so a done arriving alongside it is ignored.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state               <= ST_IDLE;
            bus.b2b_start_o     <= 1'b0;
            bus.b2b_bcd_o       <= '0;
            bus.fib_start_o     <= 1'b0;
            bus.fib_n_o         <= '0;
            bus.bin2bcd_start_o <= 1'b0;
            bus.bin2bcd_bin_o   <= '0;
            bus.result_bcd_o    <= '0;
            bus.busy_o          <= 1'b0;
            bus.done_tick_o     <= 1'b0;
            bus.error_o         <= 1'b0;
            bus.err_code_o      <= ERR_NONE;
        end else begin
            // NOTE: pulses default low here and are re-raised below; with
            // non-blocking assignment the later write in this block wins.
            bus.b2b_start_o     <= 1'b0;
            bus.fib_start_o     <= 1'b0;
            bus.bin2bcd_start_o <= 1'b0;
            bus.done_tick_o     <= 1'b0;

            case (state)
                ST_IDLE, ST_DONE, ST_ERROR: begin
                    if (bus.start_i) begin
                        bus.b2b_bcd_o  <= bus.iterations_bcd_i;
                        bus.error_o    <= 1'b0;
                        bus.err_code_o <= ERR_NONE;
                        bus.busy_o     <= 1'b1;
                        state          <= ST_CHECK;
                    end
                end

                ST_CHECK: begin
                    if (!bcd_pair_valid(bus.b2b_bcd_o)) begin
                        bus.error_o    <= 1'b1;
                        bus.err_code_o <= ERR_BCD;
                        bus.busy_o     <= 1'b0;
                        state          <= ST_ERROR;
                    end else begin
                        bus.b2b_start_o <= 1'b1;
                        state           <= ST_B2B;
                    end
                end

                ST_B2B: begin
                    if (!bus.b2b_start_o && bus.b2b_done_i) begin
                        bus.fib_n_o <= bus.b2b_bin_i;
                        if (bus.b2b_bin_i > N_W'(MAX_N)) begin
                            bus.error_o    <= 1'b1;
                            bus.err_code_o <= ERR_OVF;
                            bus.busy_o     <= 1'b0;
                            state          <= ST_ERROR;
                        end else begin
                            bus.fib_start_o <= 1'b1;
                            state           <= ST_FIB;
                        end
                    end else if (stage_timeout) begin
                        bus.error_o    <= 1'b1;
                        bus.err_code_o <= ERR_TIMEOUT;
                        bus.busy_o     <= 1'b0;
                        state          <= ST_ERROR;
                    end
                end

                ST_FIB: begin
                    if (!bus.fib_start_o && bus.fib_done_i) begin
                        bus.bin2bcd_bin_o   <= bus.fib_result_i;
                        bus.bin2bcd_start_o <= 1'b1;
                        state               <= ST_B2BCD;
                    end else if (stage_timeout) begin
                        bus.error_o    <= 1'b1;
                        bus.err_code_o <= ERR_TIMEOUT;
                        bus.busy_o     <= 1'b0;
                        state          <= ST_ERROR;
                    end
                end

                ST_B2BCD: begin
                    if (!bus.bin2bcd_start_o && bus.bin2bcd_done_i) begin
                        bus.result_bcd_o <= bus.bin2bcd_bcd_i;
                        bus.done_tick_o  <= 1'b1;
                        bus.busy_o       <= 1'b0;
                        state            <= ST_DONE;
                    end else if (stage_timeout) begin
                        bus.error_o    <= 1'b1;
                        bus.err_code_o <= ERR_TIMEOUT;
                        bus.busy_o     <= 1'b0;
                        state          <= ST_ERROR;
                    end
                end

                default: begin
                    bus.busy_o <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_sequencer.sv
// Directed scoreboard bench for fib_sequencer; the bench plays all three units.
// Covers the FIB_WATCHDOG_EN timeout when that macro is defined.
module tb_fib_sequencer;
    import fib_pkg::*;

    logic clk_i = 1'b0;
    logic reset_i;

    always #5 clk_i = ~clk_i;

    fib_sequencer_if #(.N_W(7), .RESULT_W(14)) bus ();

    fib_sequencer #(
        .N_W   (7),
        .MAX_N (20)
`ifdef FIB_WATCHDOG_EN
        ,
        .TIMEOUT_CYCLES(16)
`endif
    ) dut (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    int          n_b2b = 0;
    int          n_fib = 0;
    int          n_bcd = 0;
    int          pulse_log[$];

    always @(negedge clk_i) begin
        if (bus.b2b_start_o)     begin n_b2b++; pulse_log.push_back(1); end
        if (bus.fib_start_o)     begin n_fib++; pulse_log.push_back(2); end
        if (bus.bin2bcd_start_o) begin n_bcd++; pulse_log.push_back(3); end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench time limit");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic pulse_now(input int which);
        case (which)
            1:       return bus.b2b_start_o;
            2:       return bus.fib_start_o;
            default: return bus.bin2bcd_start_o;
        endcase
    endfunction

    function automatic logic [63:0] all_outputs();
        return {11'd0, bus.b2b_start_o, bus.b2b_bcd_o, bus.fib_start_o, bus.fib_n_o,
                bus.bin2bcd_start_o, bus.bin2bcd_bin_o, bus.result_bcd_o,
                bus.busy_o, bus.done_tick_o, bus.error_o, bus.err_code_o};
    endfunction

    task automatic wait_pulse(input int which, input string tag);
        for (int i = 0; i < 20 && !pulse_now(which); i++) step();
        check(tag, 64'(pulse_now(which)), 64'd1);
    endtask

    // Skip the pulse cycle, then answer with a one-cycle done.
    task automatic serve(input int which, input logic [15:0] value);
        step();
        case (which)
            1: begin bus.b2b_done_i = 1'b1; bus.b2b_bin_i = value[6:0]; end
            2: begin bus.fib_done_i = 1'b1; bus.fib_result_i = value[13:0]; end
            default: begin bus.bin2bcd_done_i = 1'b1; bus.bin2bcd_bcd_i = value; end
        endcase
        step();
        bus.b2b_done_i     = 1'b0;
        bus.fib_done_i     = 1'b0;
        bus.bin2bcd_done_i = 1'b0;
    endtask

    task automatic start_run(input logic [7:0] bcd);
        bus.iterations_bcd_i = bcd;
        bus.start_i          = 1'b1;
        step();
        bus.start_i          = 1'b0;
    endtask

    task automatic finish_run(input string tag);
        logic [15:0] exp;
        for (int i = 0; i < 20 && !bus.done_tick_o; i++) step();
        check({tag, "_done_tick"}, 64'(bus.done_tick_o), 64'd1);
        if (sb.size() != 0) begin
            exp = sb.pop_front();
            check({tag, "_result"}, 64'(bus.result_bcd_o), 64'(exp));
        end
        check({tag, "_error"}, 64'(bus.error_o), 64'd0);
        step();
        check({tag, "_tick_one_cycle"}, 64'(bus.done_tick_o), 64'd0);
        check({tag, "_busy_after"}, 64'(bus.busy_o), 64'd0);
    endtask

    task automatic run_ok(input string tag, input logic [7:0] bcd, input logic [6:0] n,
                          input logic [13:0] fib, input logic [15:0] res);
        sb.push_back(res);
        start_run(bcd);
        check({tag, "_busy"}, 64'(bus.busy_o), 64'd1);
        wait_pulse(1, {tag, "_b2b_pulse"});
        check({tag, "_b2b_bcd"}, 64'(bus.b2b_bcd_o), 64'(bcd));
        serve(1, 16'(n));
        wait_pulse(2, {tag, "_fib_pulse"});
        check({tag, "_fib_n"}, 64'(bus.fib_n_o), 64'(n));
        serve(2, 16'(fib));
        wait_pulse(3, {tag, "_bin2bcd_pulse"});
        check({tag, "_bin2bcd_bin"}, 64'(bus.bin2bcd_bin_o), 64'(fib));
        serve(3, res);
        finish_run(tag);
    endtask

    initial begin
        int snap;
        int order;

        bus.start_i = 1'b0;  bus.iterations_bcd_i = '0;
        bus.b2b_done_i = 1'b0; bus.b2b_bin_i = '0;
        bus.fib_done_i = 1'b0; bus.fib_result_i = '0;
        bus.bin2bcd_done_i = 1'b0; bus.bin2bcd_bcd_i = '0;
        reset_i = 1'b1;
        step();
        step();
        reset_i = 1'b0;
        check("reset_outputs", all_outputs(), 64'd0);

        // Nominal run n=15.
        pulse_log.delete();
        run_ok("nominal", 8'h15, 7'd15, 14'd610, 16'h0610);
        order = (pulse_log.size() == 3) ? pulse_log[0] * 100 + pulse_log[1] * 10 + pulse_log[2] : -1;
        check("nominal_pulse_order", 64'(order), 64'd123);

        // Bad BCD digit.
        snap = n_b2b + n_fib + n_bcd;
        start_run(8'h1A);
        step();
        check("badbcd_error", 64'(bus.error_o), 64'd1);
        check("badbcd_code", 64'(bus.err_code_o), 64'(ERR_BCD));
        check("badbcd_busy", 64'(bus.busy_o), 64'd0);
        step();
        step();
        check("badbcd_no_pulses", 64'(n_b2b + n_fib + n_bcd), 64'(snap));
        check("badbcd_result_held", 64'(bus.result_bcd_o), 64'h0610);

        // Overflow n=21.
        snap = n_fib;
        start_run(8'h21);
        wait_pulse(1, "ovf_b2b_pulse");
        serve(1, 16'd21);
        check("ovf_error", 64'(bus.error_o), 64'd1);
        check("ovf_code", 64'(bus.err_code_o), 64'(ERR_OVF));
        check("ovf_fib_n", 64'(bus.fib_n_o), 64'd21);
        step();
        step();
        check("ovf_no_fib_pulse", 64'(n_fib), 64'(snap));
        check("ovf_result_held", 64'(bus.result_bcd_o), 64'h0610);

        // Boundaries: MAX_N, 0 and 1.
        run_ok("n20", 8'h20, 7'd20, 14'd6765, 16'h6765);
        check("n20_error_cleared", 64'(bus.err_code_o), 64'(ERR_NONE));
        run_ok("n0", 8'h00, 7'd0, 14'd0, 16'h0000);
        run_ok("n1", 8'h01, 7'd1, 14'd1, 16'h0001);

        // Repeated start and early done during FIB.
        sb.push_back(16'h0013);
        snap = n_b2b;
        start_run(8'h07);
        wait_pulse(1, "early_b2b_pulse");
        serve(1, 16'd7);
        wait_pulse(2, "early_fib_pulse");
        bus.start_i = 1'b1;  bus.iterations_bcd_i = 8'h99;
        bus.fib_done_i = 1'b1; bus.fib_result_i = 14'd13;
        step();
        bus.start_i = 1'b0;
        check("early_done_ignored", 64'(bus.bin2bcd_start_o), 64'd0);
        check("early_busy", 64'(bus.busy_o), 64'd1);
        check("early_start_ignored", 64'(bus.b2b_bcd_o), 64'h07);
        step();
        bus.fib_done_i = 1'b0;
        check("late_done_accepted", 64'(bus.bin2bcd_start_o), 64'd1);
        check("late_done_bin", 64'(bus.bin2bcd_bin_o), 64'd13);
        serve(3, 16'h0013);
        finish_run("early");
        check("early_single_b2b", 64'(n_b2b), 64'(snap + 1));

        // Reset in the middle of FIB.
        start_run(8'h09);
        wait_pulse(1, "rst_b2b_pulse");
        serve(1, 16'd9);
        wait_pulse(2, "rst_fib_pulse");
        step();
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("midreset_outputs", all_outputs(), 64'd0);
        snap = n_b2b + n_fib + n_bcd;
        step();
        step();
        check("midreset_no_pulses", 64'(n_b2b + n_fib + n_bcd), 64'(snap));
        run_ok("after_reset", 8'h01, 7'd1, 14'd1, 16'h0001);

        // Start and reset together: reset wins.
        snap = n_b2b;
        bus.iterations_bcd_i = 8'h05;
        bus.start_i = 1'b1;
        reset_i     = 1'b1;
        step();
        bus.start_i = 1'b0;
        reset_i     = 1'b0;
        check("start_reset_busy", 64'(bus.busy_o), 64'd0);
        step();
        step();
        check("start_reset_no_b2b", 64'(n_b2b), 64'(snap));

        // Stalled Fibonacci engine.
        snap = n_bcd;
        start_run(8'h03);
        wait_pulse(1, "stall_b2b_pulse");
        serve(1, 16'd3);
        wait_pulse(2, "stall_fib_pulse");
`ifdef FIB_WATCHDOG_EN
        repeat (15) step();
        check("wd_not_yet", 64'(bus.error_o), 64'd0);
        step();
        check("wd_error", 64'(bus.error_o), 64'd1);
        check("wd_code", 64'(bus.err_code_o), 64'(ERR_TIMEOUT));
        step();
        step();
        check("wd_no_bin2bcd", 64'(n_bcd), 64'(snap));
`else
        repeat (100) step();
        check("stall_busy", 64'(bus.busy_o), 64'd1);
        check("stall_no_error", 64'(bus.error_o), 64'd0);
        check("stall_no_bin2bcd", 64'(n_bcd), 64'(snap));
        sb.push_back(16'h0002);
        serve(2, 16'd2);
        check("stall_resume", 64'(bus.bin2bcd_start_o), 64'd1);
        serve(3, 16'h0002);
        finish_run("stall");
`endif

        check("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
